// File: rtl/alu_pkg.sv
// Shared types for the ALU issue front-end: opcode enum and FIFO entry layout.
// Optional ALU_ISSUE_TAG_EN adds a per-op tag field to the entry.
package alu_pkg;

  localparam int unsigned OP_W  = 2;
  localparam int unsigned TAG_W = 4;
  localparam int unsigned RES_W = 16;

  typedef enum logic [OP_W-1:0] {
    ADD = 2'd0,
    SUB = 2'd1,
    MUL = 2'd2,
    DIV = 2'd3
  } op_e;

  typedef struct packed {
    op_e              op;
    logic [RES_W-1:0] r;
`ifdef ALU_ISSUE_TAG_EN
    logic [TAG_W-1:0] tag;
`endif
  } fifo_entry_t;

endpackage

// File: rtl/alu_issue_fifo.sv
// Synchronous result FIFO; power-of-two depth, naturally wrapping pointers.
// When empty the output keeps showing the most recently popped head.
module alu_issue_fifo
  import alu_pkg::*;
#(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = fifo_entry_t,
  localparam int unsigned AW     = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  entry_t        din,
  input  logic          pop,
  output entry_t        dout,
  output logic [AW:0]   count,
  output logic          full,
  output logic          empty
);

  entry_t        mem [DEPTH];
  entry_t        last;
  logic [AW-1:0] wr;
  logic [AW-1:0] rd;
  logic          push_ok;
  logic          pop_ok;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = empty ? last : mem[rd];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr] <= din;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr    <= '0;
      rd    <= '0;
      count <= '0;
      last  <= '0;
    end else begin
      if (push_ok) wr <= wr + 1'b1;
      if (pop_ok) begin
        rd   <= rd + 1'b1;
        last <= mem[rd];
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue.sv
// ALU front-end: operand registers, 2-stage valid/op pipe, result mux, credit-gated
// result FIFO. Define ALU_ISSUE_TAG_EN to carry a 4-bit tag alongside each op.
module alu_issue
  import alu_pkg::*;
#(
  parameter int unsigned IN_WL  = 15,
  parameter int unsigned OUT_WL = 16,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  op_e               in_op,
  input  logic [IN_WL-1:0]  in_a,
  input  logic [IN_WL-1:0]  in_b,
  output logic [IN_WL-1:0]  unit_a,
  output logic [IN_WL-1:0]  unit_b,
  input  logic [OUT_WL-1:0] r_add,
  input  logic [OUT_WL-1:0] r_sub,
  input  logic [OUT_WL-1:0] r_mul,
  input  logic [OUT_WL-1:0] r_div,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_WL-1:0] out_r,
  output op_e               out_op
`ifdef ALU_ISSUE_TAG_EN
  ,
  input  logic [TAG_W-1:0]  in_tag,
  output logic [TAG_W-1:0]  out_tag
`endif
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    op_e               op;
    logic [OUT_WL-1:0] r;
`ifdef ALU_ISSUE_TAG_EN
    logic [TAG_W-1:0]  tag;
`endif
  } entry_t;

  logic    v1, v2;
  op_e     op1, op2;
  logic    accept;
  logic    pop;
  logic    full, empty;
  logic [CW-1:0] count;
  logic [CW:0]   used;
  entry_t  push_data;
  entry_t  head;

`ifdef ALU_ISSUE_TAG_EN
  logic [TAG_W-1:0] tag1, tag2;
`endif

  // Counting in-flight ops against FIFO space means a pushed result always has a slot.
  assign used     = {1'b0, count} + (CW+1)'(v1) + (CW+1)'(v2);
  assign in_ready = !rst && (used < (CW+1)'(DEPTH));
  assign accept   = in_valid && in_ready;
  assign out_valid = !empty;
  assign pop      = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      unit_a <= '0;
      unit_b <= '0;
      v1     <= 1'b0;
      v2     <= 1'b0;
      op1    <= ADD;
      op2    <= ADD;
`ifdef ALU_ISSUE_TAG_EN
      tag1   <= '0;
      tag2   <= '0;
`endif
    end else begin
      if (accept) begin
        unit_a <= in_a;
        unit_b <= in_b;
        op1    <= in_op;
`ifdef ALU_ISSUE_TAG_EN
        tag1   <= in_tag;
`endif
      end
      v1  <= accept;
      v2  <= v1;
      op2 <= op1;
`ifdef ALU_ISSUE_TAG_EN
      tag2 <= tag1;
`endif
    end
  end

  always_comb begin
    push_data    = '0;
    push_data.op = op2;
    unique case (op2)
      ADD: push_data.r = r_add;
      SUB: push_data.r = r_sub;
      MUL: push_data.r = r_mul;
      DIV: push_data.r = r_div;
    endcase
`ifdef ALU_ISSUE_TAG_EN
    push_data.tag = tag2;
`endif
  end

  alu_issue_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (v2),
    .din   (push_data),
    .pop   (pop),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  assign out_r  = head.r;
  assign out_op = head.op;
`ifdef ALU_ISSUE_TAG_EN
  assign out_tag = head.tag;
`endif

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: directed scenarios plus randomized traffic
// scored against an in-order queue of expected results.
module tb_alu_issue;
  import alu_pkg::*;

  localparam int unsigned IN_WL  = 15;
  localparam int unsigned OUT_WL = 16;
  localparam int unsigned DEPTH  = 4;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  op_e               in_op;
  logic [IN_WL-1:0]  in_a, in_b;
  logic [IN_WL-1:0]  unit_a, unit_b;
  logic [OUT_WL-1:0] r_add, r_sub, r_mul, r_div;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_WL-1:0] out_r;
  op_e               out_op;
  logic [3:0]        tag_in;
  logic [3:0]        tag_out;

  alu_issue #(
    .IN_WL  (IN_WL),
    .OUT_WL (OUT_WL),
    .DEPTH  (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .unit_a    (unit_a),
    .unit_b    (unit_b),
    .r_add     (r_add),
    .r_sub     (r_sub),
    .r_mul     (r_mul),
    .r_div     (r_div),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_r     (out_r),
    .out_op    (out_op)
`ifdef ALU_ISSUE_TAG_EN
    ,
    .in_tag    (tag_in),
    .out_tag   (tag_out)
`endif
  );

`ifndef ALU_ISSUE_TAG_EN
  assign tag_out = '0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] ref_res(op_e op, logic [14:0] a, logic [14:0] b);
    case (op)
      ADD:     return 16'(a) + 16'(b);
      SUB:     return 16'(a) - 16'(b);
      MUL:     return 16'(32'(a) * 32'(b));
      default: return (b == 0) ? 16'hFFFF : 16'(a / b);
    endcase
  endfunction

  // Unit blocks: each registers its result from the shared operand bus.
  always @(posedge clk) begin
    r_add <= ref_res(ADD, unit_a, unit_b);
    r_sub <= ref_res(SUB, unit_a, unit_b);
    r_mul <= ref_res(MUL, unit_a, unit_b);
    r_div <= ref_res(DIV, unit_a, unit_b);
  end

  typedef struct {
    op_e         op;
    logic [15:0] r;
    logic [3:0]  tag;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   acc_cnt = 0;
  int   pop_cnt = 0;

  task automatic check(string name, logic [31:0] obs, logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  // Handshakes resolve at the negedge, then advance past the next posedge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    if (in_valid && in_ready) begin
      q.push_back('{in_op, ref_res(in_op, in_a, in_b), tag_in});
      acc_cnt++;
    end
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        check("spurious_out_valid", 32'(out_valid), 32'd0);
      end else begin
        e = q.pop_front();
        check("out_r", 32'(out_r), 32'(e.r));
        check("out_op", 32'(out_op), 32'(e.op));
`ifdef ALU_ISSUE_TAG_EN
        check("out_tag", 32'(tag_out), 32'(e.tag));
`endif
        pop_cnt++;
      end
    end
    @(posedge clk);
    if (rst) q.delete();
    #1;
  endtask

  task automatic drive(logic v, op_e op, logic [14:0] a, logic [14:0] b, logic [3:0] t);
    in_valid = v;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    tag_in   = t;
  endtask

  function automatic logic [14:0] rnd_b();
    return ($urandom_range(0, 7) == 0) ? 15'(0) : 15'($urandom);
  endfunction

  int base;
  logic [3:0] tags [3];
  int guard;

  initial begin
    rst = 1'b1;
    out_ready = 1'b0;
    drive(1'b1, ADD, 15'd7, 15'd9, 4'd0);

    repeat (3) begin
      tick();
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_unit_a", 32'(unit_a), 32'd0);
      check("rst_unit_b", 32'(unit_b), 32'd0);
    end
    check("rst_out_r", 32'(out_r), 32'd0);
    check("rst_out_op", 32'(out_op), 32'd0);

    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("idle_in_ready", 32'(in_ready), 32'd1);

    // Single op latency
    drive(1'b1, ADD, 15'd5, 15'd3, 4'd0);
    tick();
    in_valid = 1'b0;
    check("single_unit_a", 32'(unit_a), 32'd5);
    check("single_unit_b", 32'(unit_b), 32'd3);
    check("single_lat_e0", 32'(out_valid), 32'd0);
    tick();
    check("single_lat_e1", 32'(out_valid), 32'd0);
    tick();
    check("single_lat_e2", 32'(out_valid), 32'd1);
    check("single_out_r", 32'(out_r), 32'd8);
    check("single_out_op", 32'(out_op), 32'd0);
    repeat (2) tick();
    check("single_drained", 32'(q.size()), 32'd0);

    // Streaming: 8 back-to-back ops, one result per cycle
    base = pop_cnt;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, op_e'(i % 4), 15'($urandom), rnd_b(), 4'd0);
      check("stream_in_ready", 32'(in_ready), 32'd1);
      tick();
    end
    in_valid = 1'b0;
    repeat (3) tick();
    check("stream_pops", 32'(pop_cnt - base), 32'd8);
    check("stream_empty", 32'(out_valid), 32'd0);

    // Backpressure: credit allows exactly DEPTH accepts
    out_ready = 1'b0;
    base = acc_cnt;
    repeat (10) begin
      drive(1'b1, op_e'($urandom_range(0, 3)), 15'($urandom), rnd_b(), 4'd0);
      tick();
    end
    in_valid = 1'b0;
    check("bp_accepts", 32'(acc_cnt - base), 32'(DEPTH));
    check("bp_in_ready_full", 32'(in_ready), 32'd0);
    check("bp_out_valid", 32'(out_valid), 32'd1);
    out_ready = 1'b1;
    check("bp_ready_at_pop", 32'(in_ready), 32'd0);
    tick();
    check("bp_ready_after_pop", 32'(in_ready), 32'd1);
    repeat (4) tick();
    check("bp_drained", 32'(q.size()), 32'd0);

    // Mid-flight reset flushes everything
    drive(1'b1, MUL, 15'd100, 15'd7, 4'd0);
    tick();
    drive(1'b1, SUB, 15'd50, 15'd9, 4'd0);
    tick();
    rst = 1'b1;
    drive(1'b1, DIV, 15'd81, 15'd9, 4'd0);
    tick();
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    in_valid = 1'b0;
    repeat (4) begin
      tick();
      check("mid_rst_no_out", 32'(out_valid), 32'd0);
    end
    drive(1'b1, ADD, 15'd5, 15'd3, 4'd0);
    tick();
    in_valid = 1'b0;
    check("post_rst_lat_e0", 32'(out_valid), 32'd0);
    tick();
    check("post_rst_lat_e1", 32'(out_valid), 32'd0);
    tick();
    check("post_rst_lat_e2", 32'(out_valid), 32'd1);
    check("post_rst_out_r", 32'(out_r), 32'd8);
    repeat (2) tick();

`ifdef ALU_ISSUE_TAG_EN
    tags[0] = 4'hA;
    tags[1] = 4'h5;
    tags[2] = 4'hF;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, op_e'($urandom_range(0, 3)), 15'($urandom), rnd_b(), tags[i]);
      guard = 0;
      base = acc_cnt;
      while (acc_cnt == base && guard < 50) begin
        out_ready = 1'($urandom_range(0, 1));
        tick();
        guard++;
      end
      check("tag_accept_timeout", 32'(acc_cnt - base), 32'd1);
    end
    in_valid = 1'b0;
    guard = 0;
    while (q.size() != 0 && guard < 100) begin
      out_ready = 1'($urandom_range(0, 1));
      tick();
      guard++;
    end
    check("tag_drain", 32'(q.size()), 32'd0);
`endif

    // Randomized traffic
    repeat (300) begin
      drive(1'($urandom_range(0, 1)), op_e'($urandom_range(0, 3)), 15'($urandom), rnd_b(),
            4'($urandom));
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    guard = 0;
    while (q.size() != 0 && guard < 50) begin
      tick();
      guard++;
    end
    check("final_drain", 32'(q.size()), 32'd0);
    check("final_out_valid", 32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
